// File: rtl/parity_frame_rx.sv
// parity_frame_rx: UART-style frame deserializer feeding an even-parity checker via a valid/ready register
module parity_frame_rx #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              parity_q, parity_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    // next-state: receive FSM advances only on strobes; output register is loaded, accepted or overrun
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        data_d   = data_q;
        parity_d = parity_q;
        valid_d  = valid_q && !out_ready;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        if (rx_en) begin
            case (state_q)
                IDLE: begin
                    state_d = rx_bit ? IDLE : DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    shift_d[cnt_q] = rx_bit;
                    state_d        = (cnt_q == CW'(DATA_W - 1)) ? PARITY : DATA;
                    cnt_d          = (cnt_q == CW'(DATA_W - 1)) ? '0 : cnt_q + CW'(1);
                end
                PARITY: begin
                    par_d   = rx_bit;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (!rx_bit) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || out_ready) begin
                        data_d   = shift_q;
                        parity_d = par_q;
                        valid_d  = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // state register with synchronous reset that discards any frame in flight or held
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            data_q   <= '0;
            parity_q <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign parity_out = parity_q;
    assign out_valid  = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: randomized scenario bench for parity_frame_rx against a frame-level model
module tb_parity_frame_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b0;
    logic       rx_bit = 1'b1;
    logic       out_ready = 1'b0;
    logic [3:0] data_out;
    logic       parity_out, out_valid, frame_err, overrun, busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic       exp_valid = 1'b0;
    logic [3:0] exp_data = '0;
    logic       exp_par = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;

    parity_frame_rx #(.DATA_W(4)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_bit(rx_bit),
        .data_out(data_out), .parity_out(parity_out), .out_valid(out_valid),
        .out_ready(out_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one strobed bit, preceded by up to maxgap unstrobed cycles with a glitching line
    task automatic strobe(input logic b, input int maxgap, input logic rdy);
        int gap;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            rx_en  = 1'b0;
            rx_bit = 1'($urandom);
            tick();
        end
        rx_en     = 1'b1;
        rx_bit    = b;
        out_ready = rdy;
        tick();
        rx_en     = 1'b0;
        rx_bit    = 1'b1;
        out_ready = 1'b0;
    endtask

    // sends a whole frame and applies the frame-level rules to the model
    task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input int maxgap, input logic rdy);
        logic [6:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < 7; i++) strobe(f[i], maxgap, (i == 6) ? rdy : 1'b0);
        exp_ferr = !s;
        exp_ovr  = s && exp_valid && !rdy;
        if (s && (!exp_valid || rdy)) begin
            exp_data  = d;
            exp_par   = p;
            exp_valid = 1'b1;
        end else if (rdy) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL accept: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({out_valid, data_out, parity_out, frame_err, overrun, busy} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset: v=%b d=%h p=%b fe=%b ov=%b busy=%b expected all 0",
                     out_valid, data_out, parity_out, frame_err, overrun, busy);
        end
        for (int i = 0; i < 40; i++) begin
            rx_en  = (i % 4 == 0);
            rx_bit = 1'b1;
            tick();
            n_cmp++;
            if ({out_valid, data_out, parity_out, frame_err, overrun, busy} !== 9'b0) begin
                n_bad++;
                $display("FAIL idle_line cyc %0d: v=%b d=%h p=%b fe=%b ov=%b busy=%b expected all 0",
                         i, out_valid, data_out, parity_out, frame_err, overrun, busy);
            end
        end
        rx_en = 1'b0;
    endtask

    task automatic test_good_frame();
        send_frame(4'b1010, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({out_valid, data_out, parity_out, busy} !== {1'b1, 4'b1010, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL good_frame hold %0d: v=%b d=%b p=%b busy=%b expected 1 1010 1 0",
                         i, out_valid, data_out, parity_out, busy);
            end
            tick();
        end
        accept();
    endtask

    task automatic test_frame_err();
        send_frame(4'b1111, 1'b1, 1'b0, 0, 1'b0);
        n_cmp++;
        if ({frame_err, overrun, out_valid, busy} !== 4'b1000) begin
            n_bad++;
            $display("FAIL frame_err: fe=%b ov=%b v=%b busy=%b expected 1 0 0 0", frame_err, overrun, out_valid, busy);
        end
        tick();
        n_cmp++;
        if ({frame_err, out_valid, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL frame_err_pulse: fe=%b v=%b busy=%b expected 0 0 0", frame_err, out_valid, busy);
        end
        send_frame(4'b0000, 1'b0, 1'b1, 0, 1'b0);
        n_cmp++;
        if ({out_valid, data_out, parity_out, frame_err} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL after_ferr: v=%b d=%b p=%b fe=%b expected 1 0000 0 0", out_valid, data_out, parity_out, frame_err);
        end
        accept();
    endtask

    task automatic test_overrun();
        send_frame(4'b1111, 1'b0, 1'b1, 0, 1'b0);
        send_frame(4'b0101, 1'b0, 1'b1, 0, 1'b0);
        n_cmp++;
        if ({overrun, out_valid, data_out} !== {1'b1, 1'b1, 4'b1111}) begin
            n_bad++;
            $display("FAIL overrun: ov=%b v=%b d=%b expected 1 1 1111", overrun, out_valid, data_out);
        end
        tick();
        n_cmp++;
        if ({overrun, out_valid, data_out} !== {1'b0, 1'b1, 4'b1111}) begin
            n_bad++;
            $display("FAIL overrun_pulse: ov=%b v=%b d=%b expected 0 1 1111", overrun, out_valid, data_out);
        end
        send_frame(4'b0101, 1'b0, 1'b1, 0, 1'b1);
        n_cmp++;
        if ({overrun, out_valid, data_out} !== {1'b0, 1'b1, 4'b0101}) begin
            n_bad++;
            $display("FAIL accept_and_load: ov=%b v=%b d=%b expected 0 1 0101", overrun, out_valid, data_out);
        end
        accept();
    endtask

    task automatic test_gating();
        for (int k = 0; k < 3; k++) begin
            send_frame(4'b1010, 1'b1, 1'b1, 5, 1'b0);
            n_cmp++;
            if ({out_valid, data_out, parity_out, frame_err, overrun, busy} !== {1'b1, 4'b1010, 1'b1, 3'b000}) begin
                n_bad++;
                $display("FAIL gating %0d: v=%b d=%b p=%b fe=%b ov=%b busy=%b expected 1 1010 1 0 0 0",
                         k, out_valid, data_out, parity_out, frame_err, overrun, busy);
            end
            accept();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [3:0] d;
            logic       p, s, rdy;
            d   = 4'($urandom);
            p   = 1'($urandom);
            s   = ($urandom % 5) != 0;
            rdy = 1'($urandom);
            send_frame(d, p, s, 3, rdy);
            n_cmp++;
            if ({out_valid, data_out, parity_out, frame_err, overrun, busy} !==
                {exp_valid, exp_data, exp_par, exp_ferr, exp_ovr, 1'b0}) begin
                n_bad++;
                $display("FAIL random %0d: got v=%b d=%h p=%b fe=%b ov=%b busy=%b expected v=%b d=%h p=%b fe=%b ov=%b busy=0",
                         k, out_valid, data_out, parity_out, frame_err, overrun, busy,
                         exp_valid, exp_data, exp_par, exp_ferr, exp_ovr);
            end
            if ($urandom % 3 == 0) accept();
        end
        accept();
    endtask

    task automatic test_reset_mid();
        send_frame(4'b0110, 1'b1, 1'b1, 0, 1'b0);
        strobe(1'b0, 0, 1'b0);
        strobe(1'b1, 0, 1'b0);
        strobe(1'b1, 0, 1'b0);
        n_cmp++;
        if ({busy, out_valid} !== 2'b11) begin
            n_bad++;
            $display("FAIL mid_frame: busy=%b v=%b expected 1 1", busy, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_valid = 1'b0;
        n_cmp++;
        if ({out_valid, busy, data_out, parity_out} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_mid: v=%b busy=%b d=%b p=%b expected 0 0 0000 0", out_valid, busy, data_out, parity_out);
        end
        for (int i = 0; i < 8; i++) strobe(1'b1, 1, 1'b0);
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL post_reset_idle: v=%b busy=%b expected 0 0", out_valid, busy);
        end
        send_frame(4'b1001, 1'b0, 1'b1, 2, 1'b0);
        n_cmp++;
        if ({out_valid, data_out, parity_out} !== {1'b1, 4'b1001, 1'b0}) begin
            n_bad++;
            $display("FAIL post_reset_frame: v=%b d=%b p=%b expected 1 1001 0", out_valid, data_out, parity_out);
        end
        accept();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_frame_err();
        test_overrun();
        test_gating();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
